// File: rtl/eeprom_slave_rsp_pkg.sv
// Shared constants for the serial EEPROM responder: FSM state encoding,
// default device-type nibble and the acknowledge bit levels.
package eeprom_pkg;

  localparam logic [3:0] DEV_TYPE_DEF = 4'b1010;

  // Level of the ninth bit: low acknowledges, high declines.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // One-hot state encoding.
  typedef enum logic [9:0] {
    ST_IDLE      = 10'b00_0000_0001,
    ST_CTRL      = 10'b00_0000_0010,
    ST_CTRL_ACK  = 10'b00_0000_0100,
    ST_ADDR      = 10'b00_0000_1000,
    ST_ADDR_ACK  = 10'b00_0001_0000,
    ST_WDATA     = 10'b00_0010_0000,
    ST_WDATA_ACK = 10'b00_0100_0000,
    ST_RDATA     = 10'b00_1000_0000,
    ST_RACK      = 10'b01_0000_0000,
    ST_WAIT_STOP = 10'b10_0000_0000
  } state_t;

endpackage

// File: rtl/eeprom_slave_rsp_if.sv
// Serial-bus and write-monitor signals of the EEPROM responder.
interface eeprom_slave_rsp_if #(
  parameter int ADDR_W = 11
);
  logic              SCL;
  logic              SDA_IN;
  logic              SDA_OE;
  logic              BUSY;
  logic              WR_STB;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;

  modport master (
    output SCL, SDA_IN,
    input  SDA_OE, BUSY, WR_STB, WR_ADDR, WR_DATA
  );

  modport slave (
    input  SCL, SDA_IN,
    output SDA_OE, BUSY, WR_STB, WR_ADDR, WR_DATA
  );
endinterface

// File: rtl/eeprom_slave_rsp_i2c_line_sync.sv
// Brings SCL/SDA into the CLK domain and detects clock edges and bus
// START/STOP conditions on the synchronized lines.
module i2c_line_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_hist;
  logic       sda_hist;
  logic       scl;

  // Two-flop synchronizers plus one history flop per line; reset to the idle (high) bus level.
  // NOTE: non-blocking assignments let each flop take the previous value of its neighbour, forming a real shift chain.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
    end
  end

  assign scl      = scl_sync[1];
  assign sda      = sda_sync[1];
  assign scl_rise = scl & ~scl_hist;
  assign scl_fall = ~scl & scl_hist;

  // SDA may only move while SCL is low during data; a change with SCL held high is a bus condition.
  assign start_det = scl & scl_hist & sda_hist & ~sda;
  assign stop_det  = scl & scl_hist & ~sda_hist & sda;

endmodule

// File: rtl/eeprom_slave_rsp.sv
// Serial EEPROM responder: decodes control/address/data bytes from the
// 2-wire master, acknowledges owned bytes and serves an internal byte array.
module eeprom_slave_rsp
  import eeprom_pkg::*;
#(
  parameter int         ADDR_W   = 11,
  parameter logic [3:0] DEV_TYPE = DEV_TYPE_DEF,
  parameter logic [7:0] INIT_VAL = 8'hFF
) (
  input logic              CLK,
  input logic              RESET,
  eeprom_slave_rsp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  // Address bits above the address byte travel in control byte bits [3:1].
  localparam int BLK_W = ADDR_W - 8;

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .CLK       (CLK),
    .RESET     (RESET),
    .scl_in    (bus.SCL),
    .sda_in    (bus.SDA_IN),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
  logic              rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic [7:0] mem [DEPTH] = '{default: INIT_VAL};
  logic [7:0] rd_byte;
  logic [7:0] rx_byte;

  assign rd_byte = mem[addr_ptr_q];
  assign rx_byte = {shreg_q[6:0], sda};

  // Next-state and datapath decisions; SDA_OE only moves on an SCL fall.
  // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    addr_ptr_d = addr_ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ST_CTRL;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_WAIT_STOP: sda_oe_d = 1'b0;

        ST_CTRL: if (scl_rise) begin
          shreg_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (rx_byte[7:4] == DEV_TYPE) begin
              state_d = ST_CTRL_ACK;
              rw_d    = rx_byte[0];
              // A read keeps the pointer so a dummy write can set up a random read.
              if (!rx_byte[0]) addr_ptr_d = {rx_byte[BLK_W:1], addr_ptr_q[7:0]};
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end

        // First fall after the byte drives ACK, the second releases it.
        ST_CTRL_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = ~ACK;
          end else if (rw_q) begin
            state_d   = ST_RDATA;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = 4'd1;
          end else begin
            state_d  = ST_ADDR;
            sda_oe_d = 1'b0;
          end
        end

        ST_ADDR: if (scl_rise) begin
          shreg_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d        = '0;
            addr_ptr_d[7:0]  = rx_byte;
            state_d          = ST_ADDR_ACK;
          end
        end

        ST_ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = ~ACK;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_WDATA;
          end
        end

        ST_WDATA: if (scl_rise) begin
          shreg_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            state_d   = ST_WDATA_ACK;
          end
        end

        // The byte is committed on the ACK fall; the pointer advances for a sequential write.
        ST_WDATA_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d   = ~ACK;
            wr_stb_d   = 1'b1;
            wr_addr_d  = addr_ptr_q;
            wr_data_d  = shreg_q;
            addr_ptr_d = addr_ptr_q + 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_WDATA;
          end
        end

        // bit_cnt counts bits already placed on the line.
        ST_RDATA: if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d   = 1'b0;
            bit_cnt_d  = '0;
            addr_ptr_d = addr_ptr_q + 1'b1;
            state_d    = ST_RACK;
          end else begin
            sda_oe_d  = ~rd_byte[3'd7 - bit_cnt_q[2:0]];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end

        ST_RACK: if (scl_rise) begin
          if (sda == ACK) begin
            state_d   = ST_RDATA;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_WAIT_STOP;
          end
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; reset releases SDA at once and drops any pending write.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      addr_ptr_q <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      addr_ptr_q <= addr_ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Array write one CLK after the strobe is registered.
  // NOTE: the array has no reset; its erased content comes from the declaration and must survive RESET.
  always_ff @(posedge CLK) begin
    if (wr_stb_q) mem[wr_addr_q] <= wr_data_q;
  end

  assign bus.SDA_OE  = sda_oe_q;
  assign bus.BUSY    = busy_q;
  assign bus.WR_STB  = wr_stb_q;
  assign bus.WR_ADDR = wr_addr_q;
  assign bus.WR_DATA = wr_data_q;

endmodule

// File: tb/tb_eeprom_slave_rsp.sv
// Bench for eeprom_slave_rsp: a bit-level bus master drives directed and
// random transactions; a byte-array model predicts reads and writes.
module tb_eeprom_slave_rsp;

  localparam int ADDR_W = 11;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  logic m_low = 1'b0;   // master pulling SDA low

  eeprom_slave_rsp_if #(.ADDR_W(ADDR_W)) bus ();

  eeprom_slave_rsp #(
    .ADDR_W   (ADDR_W),
    .DEV_TYPE (4'b1010),
    .INIT_VAL (8'hFF)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // Open-drain SDA: low if either side pulls.
  assign bus.SDA_IN = ~(m_low | bus.SDA_OE);

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  model_mem [2048];
  logic [18:0] exp_wq [$];     // {addr, data} of expected commits
  logic [7:0]  wbuf [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Commit monitor: every WR_STB must match the next expected write.
  always @(posedge CLK) begin
    #2;
    if (bus.WR_STB === 1'b1) begin
      check("wr_pending", 32'(exp_wq.size() > 0), 1);
      if (exp_wq.size() > 0) begin
        logic [18:0] e;
        e = exp_wq.pop_front();
        check("wr_addr", bus.WR_ADDR, e[18:8]);
        check("wr_data", bus.WR_DATA, e[7:0]);
      end
    end
  end

  // SDA_OE may only change while SCL is low.
  logic oe_prev = 1'b0;
  always @(posedge CLK) begin
    #2;
    if (!RESET && bus.SDA_OE !== oe_prev) check("oe_edge_scl_low", bus.SCL, 0);
    oe_prev = bus.SDA_OE;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_clk(2);
    bus.SCL = 1'b1; wait_clk(4);
    m_low = 1'b1; wait_clk(4);
    bus.SCL = 1'b0; wait_clk(2);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_clk(2);
    bus.SCL = 1'b1; wait_clk(4);
    m_low = 1'b0; wait_clk(4);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_low = ~b[i]; wait_clk(2);
      bus.SCL = 1'b1; wait_clk(4);
      bus.SCL = 1'b0; wait_clk(2);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    m_low = 1'b0; wait_clk(2);
    bus.SCL = 1'b1; wait_clk(2);
    ack = bus.SDA_IN; wait_clk(2);
    bus.SCL = 1'b0; wait_clk(2);
  endtask

  // mack: 0 acknowledges (more bytes wanted), 1 ends the read.
  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_low = 1'b0; wait_clk(2);
      bus.SCL = 1'b1; wait_clk(2);
      b[i] = bus.SDA_IN; wait_clk(2);
      bus.SCL = 1'b0; wait_clk(2);
    end
    m_low = ~mack; wait_clk(2);
    bus.SCL = 1'b1; wait_clk(4);
    bus.SCL = 1'b0; wait_clk(2);
  endtask

  task automatic do_write(input logic [10:0] a, input int n);
    logic ack;
    logic [10:0] p;
    i2c_start();
    check("busy_after_start", bus.BUSY, 1);
    send_byte({4'b1010, a[10:8], 1'b0}, ack); check("wr_ctrl_ack", ack, 0);
    send_byte(a[7:0], ack);                   check("wr_addr_ack", ack, 0);
    p = a;
    for (int j = 0; j < n; j++) begin
      exp_wq.push_back({p, wbuf[j]});
      model_mem[p] = wbuf[j];
      send_byte(wbuf[j], ack); check("wr_data_ack", ack, 0);
      p = p + 11'd1;
    end
    i2c_stop(); wait_clk(4);
    check("busy_after_stop", bus.BUSY, 0);
    check("oe_after_stop", bus.SDA_OE, 0);
  endtask

  task automatic do_read(input logic [10:0] a, input int n);
    logic ack;
    logic [7:0] b;
    logic [10:0] p;
    i2c_start();
    send_byte({4'b1010, a[10:8], 1'b0}, ack); check("rd_dummy_ctrl_ack", ack, 0);
    send_byte(a[7:0], ack);                   check("rd_addr_ack", ack, 0);
    i2c_start();
    send_byte({4'b1010, 3'b000, 1'b1}, ack);  check("rd_ctrl_ack", ack, 0);
    p = a;
    for (int j = 0; j < n; j++) begin
      read_byte((j == n - 1) ? 1'b1 : 1'b0, b);
      check("rd_data", b, model_mem[p]);
      p = p + 11'd1;
    end
    i2c_stop(); wait_clk(4);
    check("rd_oe_after_stop", bus.SDA_OE, 0);
    check("rd_busy_after_stop", bus.BUSY, 0);
  endtask

  initial begin
    logic ack;
    logic [10:0] a, ra;
    int n, k;

    for (int i = 0; i < 2048; i++) model_mem[i] = 8'hFF;
    bus.SCL = 1'b1;
    wait_clk(3);
    check("rst_oe", bus.SDA_OE, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_wr_stb", bus.WR_STB, 0);
    check("rst_wr_addr", bus.WR_ADDR, 0);
    check("rst_wr_data", bus.WR_DATA, 0);
    RESET = 1'b0;
    wait_clk(4);

    // Byte write, then random read of the same location.
    wbuf[0] = 8'h5A;
    do_write(11'h134, 1);
    do_read(11'h134, 1);

    // Sequential write and read across the top-of-array wrap.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(11'h7FF, 2);
    do_read(11'h7FF, 2);

    // Wrong device type: nothing acknowledged, nothing written.
    i2c_start();
    send_byte(8'hB0, ack); check("wrongdev_ctrl_nack", ack, 1);
    send_byte(8'h34, ack); check("wrongdev_addr_nack", ack, 1);
    send_byte(8'h99, ack); check("wrongdev_data_nack", ack, 1);
    i2c_stop(); wait_clk(4);
    check("wrongdev_busy", bus.BUSY, 0);

    // STOP after four data bits discards the partial byte.
    i2c_start();
    send_byte(8'hA2, ack); check("abort_ctrl_ack", ack, 0);
    send_byte(8'h34, ack); check("abort_addr_ack", ack, 0);
    send_bits(8'hC3, 4);
    i2c_stop(); wait_clk(4);
    check("abort_busy", bus.BUSY, 0);
    do_read(11'h134, 1);

    // RESET while the responder pulls SDA low.
    i2c_start();
    send_bits(8'hA2, 8);
    m_low = 1'b0;
    k = 0;
    while (bus.SDA_OE !== 1'b1 && k < 20) begin wait_clk(1); k++; end
    check("ack_seen_before_reset", bus.SDA_OE, 1);
    @(posedge CLK); #3;
    RESET = 1'b1;
    #1;
    check("reset_oe_async", bus.SDA_OE, 0);
    check("reset_busy", bus.BUSY, 0);
    wait_clk(3);
    RESET = 1'b0;
    wait_clk(2);
    i2c_stop(); wait_clk(4);
    wbuf[0] = 8'hC7;
    do_write(11'h2A5, 1);
    do_read(11'h2A5, 1);

    // Random writes and overlapping read-backs.
    for (int it = 0; it < 8; it++) begin
      a = 11'($urandom_range(0, 2047));
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) wbuf[j] = 8'($urandom);
      do_write(a, n);
      ra = a - 11'($urandom_range(0, 1));
      do_read(ra, n + 1);
    end

    wait_clk(10);
    check("wr_queue_drained", exp_wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eeprom_slave_rsp.md
Name: eeprom_slave_rsp

Overview:
- Synthesizable responder for the 2-wire serial EEPROM protocol driven by the EEPROM master controller.
- Decodes START/STOP, control byte, word address and data, and ACKs each byte it owns.
- Writes or returns bytes from an internal 2^ADDR_W x 8 array.
- Used as the on-chip/bench memory model, so the master can be closed-loop tested and also run against real silicon timing.

Parameters:
- ADDR_W, 11, word address width; control byte carries ADDR[10:8], address byte carries ADDR[7:0].
- DEV_TYPE, 4'b1010, device-type nibble expected in control byte bits [7:4].
- INIT_VAL, 8'hFF, reset/erased content of the memory array (applied only at instantiation, not on RESET).

Ports:
- CLK  input  1  system clock; must run at least 8x SCL frequency.
- RESET  input  1  asynchronous, active-high reset.
- SCL  input  1  serial clock from master, asynchronous to CLK.
- SDA_IN  input  1  sampled value of the SDA line, asynchronous.
- SDA_OE  output  1  1 = pull SDA low (open drain); 0 = release; pad does assign SDA = SDA_OE ? 1'b0 : 1'bz.
- BUSY  output  1  high from a decoded START to STOP or reset.
- WR_STB  output  1  one-CLK pulse when a byte is committed to the array.
- WR_ADDR  output  ADDR_W  address of the committed byte (valid with WR_STB).
- WR_DATA  output  8  committed byte (valid with WR_STB).

Behaviour:
- Reset: SDA_OE=0, BUSY=0, WR_STB=0, WR_ADDR=0, WR_DATA=0, state=IDLE, bit_cnt=0, addr_ptr=0. Memory contents are not cleared.
- Input sync: SCL and SDA_IN each pass through 2 flops plus 1 history flop. All decisions use synced values.
  - scl_rise/scl_fall are single-cycle edge pulses.
  - START = synced SDA falls while synced SCL high. STOP = synced SDA rises while synced SCL high.
- SCL high and low phases must each last at least 4 CLK.
- SDA sampling and driving:
  - Shift-in samples SDA on scl_rise, MSB first.
  - SDA_OE changes only on the CLK after scl_fall. It is never changed while SCL is high.
- States: IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
- Transitions:
  - START from any state (including repeated START mid-byte): go to CTRL, bit_cnt=0, SDA_OE=0, BUSY=1.
  - STOP from any state: go to IDLE, SDA_OE=0, BUSY=0. A partial byte is discarded.
  - CTRL, 8 bits received:
    - If ctrl[7:4]==DEV_TYPE: ACK. ctrl[0]=0 loads addr_ptr[10:8]=ctrl[3:1]. ctrl[0]=1 keeps addr_ptr (random read via the preceding dummy write).
    - Otherwise: no ACK (SDA_OE stays 0), go to WAIT_STOP.
  - CTRL_ACK:
    - SDA_OE=1 on the fall after bit 8, released on the next fall.
    - Then go to ADDR if write, or to RDATA if read.
    - For read, bit 7 of mem[addr_ptr] is driven on that same release fall.
  - ADDR: 8 bits load addr_ptr[7:0]; ACK in ADDR_ACK, then go to WDATA.
  - WDATA: 8 bits. At the ACK fall: mem[addr_ptr] <= byte, WR_STB pulses 1 CLK with WR_ADDR/WR_DATA, and addr_ptr increments. Then WDATA_ACK, then back to WDATA for sequential write.
  - RDATA:
    - On each scl_fall, SDA_OE = ~current_bit. Bit 7 first.
    - After the 8th bit, SDA_OE=0 and the FSM goes to RACK.
    - addr_ptr increments when the 8th bit completes.
  - RACK: master bit sampled on scl_rise. 0 (ACK) → RDATA with the next byte. 1 (NACK) → WAIT_STOP.
  - WAIT_STOP: SDA_OE=0. Leaves only on START or STOP.
- addr_ptr wraps 2^ADDR_W-1 → 0 on both read and write.
- Simultaneous START/STOP cannot occur on one synced edge. STOP has priority if both flags appear in the same CLK.
- Reset mid-transfer releases SDA immediately (asynchronously) and aborts any pending write.

Decomposition:
- Package eeprom_pkg holds:
  - State encoding constants (one-hot, 10 bits).
  - DEV_TYPE default.
  - ACK=0 / NACK=1 constants.
- One sub-module is natural: i2c_line_sync. It contains the 2-flop synchronizers and the START/STOP/scl_rise/scl_fall detector, and is reusable by the master.
- The memory array stays inline.

Test Plan:
- Byte write: START, ctrl 8'hA2, addr 8'h34, data 8'h5A, STOP → three ACK low pulses; WR_STB once with WR_ADDR=11'h134, WR_DATA=8'h5A; BUSY falls after STOP.
- Random read: write 8'h5A at 11'h134; then START, 8'hA2, 8'h34, repeated START, 8'hA3 → ACK, then SDA_OE pattern gives 8'h5A MSB first; master NACK, STOP → SDA_OE=0, BUSY=0.
- Sequential write/read with wrap: write 8'h11, 8'h22 starting at 11'h7FF → mem[7FF]=11, mem[000]=22; sequential read from 11'h7FF with master ACK then NACK returns 11, 22.
- Wrong device: ctrl 8'hB0 → SDA_OE stays 0 through the 9th clock; no WR_STB; data bytes ignored until the next START.
- Aborts:
  - STOP after 4 data bits → no WR_STB, IDLE.
  - RESET pulsed while SDA_OE=1 → SDA_OE=0 within the same CLK, BUSY=0, next transaction works.
- Timing check: SCL at CLK/8 → SDA_OE edges occur only while synced SCL is low (assertion on every cycle).
